// File: rtl/mem_line_responder_pkg.sv
// Shared types and size helpers for the memory-side line responder and the
// cache controller that talks to it.
package mem_line_responder_pkg;

   // Responder sequencing states; busy is high in every state except IDLE.
   typedef enum logic [2:0] {
      IDLE,
      FETCH_WAIT,
      FETCH_BURST,
      FETCH_DONE,
      WB_COLLECT,
      WB_DONE
   } mem_resp_state_t;

   // Number of data words in one cache line.
   function automatic int calc_words_per_block(input int block_size, input int data_width);
      return block_size / (data_width / 8);
   endfunction

   // Width of the word-offset field inside a block address.
   function automatic int calc_offset_width(input int block_size, input int data_width);
      return $clog2(calc_words_per_block(block_size, data_width));
   endfunction

endpackage

// File: rtl/mem_line_responder_if.sv
// Line-fill / write-back bus between the cache controller (master) and the
// memory responder (slave).
interface mem_line_responder_if
   import mem_line_responder_pkg::*;
#(
   parameter int ADDRESS_WIDTH = 32,
   parameter int DATA_WIDTH    = 32,
   parameter int BLOCK_SIZE    = 32
) ();

   localparam int OFFSET_WIDTH = calc_offset_width(BLOCK_SIZE, DATA_WIDTH);

   logic                     fetch_request;
   logic [ADDRESS_WIDTH-1:0] fetch_address;
   logic                     fetch_accept;
   logic [DATA_WIDTH-1:0]    fill_data;
   logic                     fill_word_valid;
   logic [OFFSET_WIDTH-1:0]  fill_word_index;
   logic                     line_fill_valid;
   logic                     wb_request;
   logic [ADDRESS_WIDTH-1:0] wb_address;
   logic [DATA_WIDTH-1:0]    wb_data;
   logic                     wb_word_valid;
   logic                     wb_accept;
   logic                     wb_done;
   logic                     busy;

   modport master (
      output fetch_request, fetch_address, wb_request, wb_address, wb_data, wb_word_valid,
      input  fetch_accept, fill_data, fill_word_valid, fill_word_index, line_fill_valid,
             wb_accept, wb_done, busy
   );

   modport slave (
      input  fetch_request, fetch_address, wb_request, wb_address, wb_data, wb_word_valid,
      output fetch_accept, fill_data, fill_word_valid, fill_word_index, line_fill_valid,
             wb_accept, wb_done, busy
   );

endinterface

// File: rtl/mem_word_array.sv
// Single-port backing store: synchronous write, registered read that returns
// zero on cycles without a read so the fill bus idles at 0.
module mem_word_array #(
   parameter int DEPTH      = 1024,
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  en,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // Store a word on a write access.
   // NOTE: the array itself has no reset, so it maps onto plain RAM and keeps
   // its contents across a reset; only the read register below is cleared.
   always_ff @(posedge clk) begin
      if (en && we) begin
         mem[addr] <= wdata;
      end
   end

   // Register the read word; zero whenever no read is issued.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rdata <= '0;
      end else if (en && !we) begin
         rdata <= mem[addr];
      end else begin
         rdata <= '0;
      end
   end

endmodule

// File: rtl/mem_line_responder.sv
// Memory-side responder: serves block fetches as a fixed-latency word burst and
// absorbs dirty-victim write-backs beat by beat. Write-back wins arbitration.
module mem_line_responder
   import mem_line_responder_pkg::*;
#(
   parameter int ADDRESS_WIDTH   = 32,
   parameter int DATA_WIDTH      = 32,
   parameter int BLOCK_SIZE      = 32,
   parameter int MEM_DEPTH_WORDS = 1024,
   parameter int READ_LATENCY    = 4
) (
   input logic                 clk,
   input logic                 reset_n,
   mem_line_responder_if.slave bus
);

   localparam int WORDS_PER_BLOCK = calc_words_per_block(BLOCK_SIZE, DATA_WIDTH);
   localparam int OFFSET_WIDTH    = calc_offset_width(BLOCK_SIZE, DATA_WIDTH);
   localparam int MEM_AW          = $clog2(MEM_DEPTH_WORDS);
   localparam int BLOCK_NUM_W     = MEM_AW - OFFSET_WIDTH;
   localparam int LAT_W           = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

   localparam logic [OFFSET_WIDTH-1:0] LAST_BEAT = OFFSET_WIDTH'(WORDS_PER_BLOCK - 1);
   localparam logic [LAT_W-1:0]        LAT_LOAD  = LAT_W'(READ_LATENCY - 1);

   mem_resp_state_t         state;
   logic [BLOCK_NUM_W-1:0]  block_num;   // block base, already reduced modulo the store depth
   logic [LAT_W-1:0]        lat_cnt;
   logic [OFFSET_WIDTH-1:0] beat;
   logic                    fetch_accept_q;
   logic                    wb_accept_q;
   logic                    wb_done_q;
   logic                    line_fill_valid_q;
   logic                    fill_word_valid_q;
   logic [OFFSET_WIDTH-1:0] fill_word_index_q;

   logic                    mem_en;
   logic                    mem_we;
   logic [OFFSET_WIDTH-1:0] mem_offset;
   logic [MEM_AW-1:0]       mem_addr;
   logic [DATA_WIDTH-1:0]   mem_rdata;

   // Upper address bits wrap away and offset bits are ignored by design.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{bus.fetch_address[ADDRESS_WIDTH-1:MEM_AW], bus.fetch_address[OFFSET_WIDTH-1:0],
                               bus.wb_address[ADDRESS_WIDTH-1:MEM_AW], bus.wb_address[OFFSET_WIDTH-1:0]};

   // Choose the storage access for this cycle: read one word ahead of the fill
   // beat so the registered read lines up with fill_word_valid.
   // NOTE: every signal gets a default before the case so no latch is inferred.
   always_comb begin
      mem_en     = 1'b0;
      mem_we     = 1'b0;
      mem_offset = '0;
      case (state)
         FETCH_WAIT:  mem_en = (lat_cnt == '0);
         FETCH_BURST: begin
            if (beat != LAST_BEAT) begin
               mem_en     = 1'b1;
               mem_offset = beat + 1'b1;
            end
         end
         WB_COLLECT: begin
            if (bus.wb_word_valid) begin
               mem_en     = 1'b1;
               mem_we     = 1'b1;
               mem_offset = beat;
            end
         end
         default: ;
      endcase
   end

   // Base is block aligned and the depth is a multiple of the line, so
   // concatenating the offset is the same as adding it modulo the depth.
   assign mem_addr = {block_num, mem_offset};

   mem_word_array #(
      .DEPTH      (MEM_DEPTH_WORDS),
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (MEM_AW)
   ) u_array (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (mem_en),
      .we      (mem_we),
      .addr    (mem_addr),
      .wdata   (bus.wb_data),
      .rdata   (mem_rdata)
   );

   // Sequencer: arbitration, latency count, burst and beat tracking, pulses.
   // NOTE: all state here uses non-blocking assignments so every register
   // samples the values from before the edge, independent of statement order.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state             <= IDLE;
         block_num         <= '0;
         lat_cnt           <= '0;
         beat              <= '0;
         fetch_accept_q    <= 1'b0;
         wb_accept_q       <= 1'b0;
         wb_done_q         <= 1'b0;
         line_fill_valid_q <= 1'b0;
         fill_word_valid_q <= 1'b0;
         fill_word_index_q <= '0;
      end else begin
         fetch_accept_q    <= 1'b0;
         wb_accept_q       <= 1'b0;
         wb_done_q         <= 1'b0;
         line_fill_valid_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.wb_request) begin
                  state       <= WB_COLLECT;
                  block_num   <= bus.wb_address[MEM_AW-1:OFFSET_WIDTH];
                  beat        <= '0;
                  wb_accept_q <= 1'b1;
               end else if (bus.fetch_request) begin
                  state          <= FETCH_WAIT;
                  block_num      <= bus.fetch_address[MEM_AW-1:OFFSET_WIDTH];
                  lat_cnt        <= LAT_LOAD;
                  fetch_accept_q <= 1'b1;
               end
            end
            FETCH_WAIT: begin
               if (lat_cnt == '0) begin
                  state             <= FETCH_BURST;
                  beat              <= '0;
                  fill_word_valid_q <= 1'b1;
                  fill_word_index_q <= '0;
               end else begin
                  lat_cnt <= lat_cnt - 1'b1;
               end
            end
            FETCH_BURST: begin
               if (beat == LAST_BEAT) begin
                  state             <= FETCH_DONE;
                  beat              <= '0;
                  fill_word_valid_q <= 1'b0;
                  fill_word_index_q <= '0;
                  line_fill_valid_q <= 1'b1;
               end else begin
                  beat              <= beat + 1'b1;
                  fill_word_index_q <= beat + 1'b1;
               end
            end
            WB_COLLECT: begin
               if (bus.wb_word_valid) begin
                  if (beat == LAST_BEAT) begin
                     state     <= WB_DONE;
                     beat      <= '0;
                     wb_done_q <= 1'b1;
                  end else begin
                     beat <= beat + 1'b1;
                  end
               end
            end
            FETCH_DONE, WB_DONE: state <= IDLE;
            default:             state <= IDLE;
         endcase
      end
   end

   assign bus.fetch_accept    = fetch_accept_q;
   assign bus.wb_accept       = wb_accept_q;
   assign bus.wb_done         = wb_done_q;
   assign bus.line_fill_valid = line_fill_valid_q;
   assign bus.fill_word_valid = fill_word_valid_q;
   assign bus.fill_word_index = fill_word_index_q;
   assign bus.fill_data       = mem_rdata;
   assign bus.busy            = (state != IDLE);

endmodule

// File: tb/tb_mem_line_responder.sv
// Directed bench for mem_line_responder: a shadow memory model feeds a
// scoreboard of expected fill beats, popped as the responder produces them.
module tb_mem_line_responder;

   localparam int AW    = 32;
   localparam int DW    = 32;
   localparam int BS    = 32;
   localparam int DEPTH = 1024;
   localparam int RL    = 4;
   localparam int WPB   = 8;

   typedef struct {
      logic [DW-1:0] data;
      logic [2:0]    idx;
   } fill_exp_t;

   logic clk;
   logic reset_n;

   logic [DW-1:0] model_mem [DEPTH];
   fill_exp_t     exp_q [$];

   int n_asserts;
   int n_fail;

   mem_line_responder_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .BLOCK_SIZE(BS)) bus ();

   mem_line_responder #(
      .ADDRESS_WIDTH   (AW),
      .DATA_WIDTH      (DW),
      .BLOCK_SIZE      (BS),
      .MEM_DEPTH_WORDS (DEPTH),
      .READ_LATENCY    (RL)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, " fetch_accept"},    64'(bus.fetch_accept),    64'd0);
      check({tag, " fill_data"},       64'(bus.fill_data),       64'd0);
      check({tag, " fill_word_valid"}, 64'(bus.fill_word_valid), 64'd0);
      check({tag, " fill_word_index"}, 64'(bus.fill_word_index), 64'd0);
      check({tag, " line_fill_valid"}, 64'(bus.line_fill_valid), 64'd0);
      check({tag, " wb_accept"},       64'(bus.wb_accept),       64'd0);
      check({tag, " wb_done"},         64'(bus.wb_done),         64'd0);
      check({tag, " busy"},            64'(bus.busy),            64'd0);
   endtask

   // Write-back of one line: data first, first+1, ... at offsets 0..7.
   // A bogus beat is driven during the accept cycle; it must not be stored.
   task automatic do_wb(input logic [AW-1:0] addr, input logic [DW-1:0] first,
                        input bit gaps, input bit with_fetch);
      int  base;
      int  waited;
      bit  seen;
      base = int'(addr[9:0]) & ~(WPB - 1);
      bus.wb_request    = 1'b1;
      bus.wb_address    = addr;
      bus.wb_word_valid = 1'b1;
      bus.wb_data       = 32'hDEAD_BEEF;
      if (with_fetch) begin
         bus.fetch_request = 1'b1;
         bus.fetch_address = addr;
      end
      seen   = 1'b0;
      waited = 0;
      while (!seen && waited < 50) begin
         @(negedge clk);
         waited++;
         seen = bus.wb_accept;
      end
      check("wb_accept seen", 64'(seen), 64'd1);
      if (!seen) begin
         bus.wb_request    = 1'b0;
         bus.wb_word_valid = 1'b0;
         bus.fetch_request = 1'b0;
         return;
      end
      check("wb busy", 64'(bus.busy), 64'd1);
      for (int k = 0; k < WPB; k++) begin
         if (gaps && k > 0) begin
            bus.wb_word_valid = 1'b0;
            bus.wb_data       = 32'hBAD0_0000;
            @(negedge clk);
            check("wb_done during gap", 64'(bus.wb_done), 64'd0);
         end
         bus.wb_word_valid = 1'b1;
         bus.wb_data       = first + DW'(k);
         @(negedge clk);
         bus.wb_word_valid = 1'b0;
         if (k == 0) check("wb_accept single pulse", 64'(bus.wb_accept), 64'd0);
         if (with_fetch) check("fetch held off by wb", 64'(bus.fetch_accept), 64'd0);
         check($sformatf("wb_done after beat %0d", k), 64'(bus.wb_done), (k == WPB - 1) ? 64'd1 : 64'd0);
      end
      bus.wb_request = 1'b0;
      for (int k = 0; k < WPB; k++) model_mem[base + k] = first + DW'(k);
      @(negedge clk);
      check("wb_done single pulse", 64'(bus.wb_done), 64'd0);
      check("busy after wb", 64'(bus.busy), 64'd0);
   endtask

   // Fetch of one line; abort_at >= 0 asserts reset while that word is shown.
   // exp_wait > 0 also checks how many cycles the accept took to appear.
   task automatic do_fetch(input logic [AW-1:0] addr, input int abort_at, input int exp_wait);
      int        base;
      int        waited;
      bit        seen;
      fill_exp_t e;
      base = int'(addr[9:0]) & ~(WPB - 1);
      for (int i = 0; i < WPB; i++) exp_q.push_back('{model_mem[base + i], 3'(i)});
      bus.fetch_request = 1'b1;
      bus.fetch_address = addr;
      seen   = 1'b0;
      waited = 0;
      while (!seen && waited < 50) begin
         @(negedge clk);
         waited++;
         seen = bus.fetch_accept;
      end
      check("fetch_accept seen", 64'(seen), 64'd1);
      if (!seen) begin
         bus.fetch_request = 1'b0;
         exp_q.delete();
         return;
      end
      if (exp_wait > 0) check("fetch accept delay", 64'(waited), 64'(exp_wait));
      check("fetch busy", 64'(bus.busy), 64'd1);
      for (int c = 1; c < RL; c++) begin
         @(negedge clk);
         check("fetch_accept single pulse", 64'(bus.fetch_accept), 64'd0);
         check("fill valid before latency", 64'(bus.fill_word_valid), 64'd0);
         check("fill_data zero while waiting", 64'(bus.fill_data), 64'd0);
      end
      for (int k = 0; k < WPB; k++) begin
         @(negedge clk);
         check($sformatf("fill_word_valid beat %0d", k), 64'(bus.fill_word_valid), 64'd1);
         check("line_fill_valid during burst", 64'(bus.line_fill_valid), 64'd0);
         if (bus.fill_word_valid) begin
            check("scoreboard has entry", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check($sformatf("fill_data @%0h beat %0d", base, k), 64'(bus.fill_data), 64'(e.data));
               check($sformatf("fill_word_index beat %0d", k), 64'(bus.fill_word_index), 64'(e.idx));
            end
         end
         if (k == abort_at) begin
            reset_n = 1'b0;
            #1;
            check_outputs_zero("mid-burst reset");
            exp_q.delete();
            bus.fetch_request = 1'b0;
            @(negedge clk);
            reset_n = 1'b1;
            @(negedge clk);
            check_outputs_zero("after abort");
            return;
         end
      end
      @(negedge clk);
      check("line_fill_valid after last beat", 64'(bus.line_fill_valid), 64'd1);
      check("fill valid off after burst", 64'(bus.fill_word_valid), 64'd0);
      check("fill_data zero after burst", 64'(bus.fill_data), 64'd0);
      check("fill_word_index zero after burst", 64'(bus.fill_word_index), 64'd0);
      check("scoreboard drained", 64'(exp_q.size()), 64'd0);
      bus.fetch_request = 1'b0;
      @(negedge clk);
      check("line_fill_valid single pulse", 64'(bus.line_fill_valid), 64'd0);
      check("busy after fetch", 64'(bus.busy), 64'd0);
   endtask

   initial begin
      n_asserts = 0;
      n_fail    = 0;
      reset_n           = 1'b0;
      bus.fetch_request = 1'b0;
      bus.fetch_address = '0;
      bus.wb_request    = 1'b0;
      bus.wb_address    = '0;
      bus.wb_data       = '0;
      bus.wb_word_valid = 1'b0;
      repeat (3) @(negedge clk);
      check_outputs_zero("in reset");
      reset_n = 1'b1;
      @(negedge clk);
      check_outputs_zero("idle after reset");

      // Line 0x40, back-to-back beats; fetch with nonzero offset bits.
      do_wb(32'h40, 32'hA0, 1'b0, 1'b0);
      do_fetch(32'h43, -1, 0);

      // Reset while word 3 is on the bus, then the same line must still be there.
      do_fetch(32'h40, 3, 0);
      do_fetch(32'h40, -1, 0);

      // Simultaneous requests: write-back first, fetch one cycle after wb_done.
      do_wb(32'h80, 32'hB0, 1'b0, 1'b1);
      do_fetch(32'h80, -1, 1);

      // Write-back beats with a gap cycle between each.
      do_wb(32'hC0, 32'hC0, 1'b1, 1'b0);
      do_fetch(32'hC0, -1, 0);

      // Upper address bits wrap: 1024+0x08 aliases block 0x08.
      do_wb(32'd1024 + 32'h08, 32'hD0, 1'b0, 1'b0);
      do_fetch(32'h08, -1, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
